// File: rtl/inv_pipe_pkg.sv
// Shared definitions for the inv_pipe block: size limits, counter width,
// the reset value of the invert mask and the parity helper.
// Optional feature macro used by the block: INV_PIPE_PARITY_EN.
package inv_pipe_pkg;

  // Widest data word and deepest pipeline the block is built for.
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MAX = 8;

  // Width of the delivered-word counter.
  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // After reset every data bit is inverted, so the block behaves as a plain NOT.
  localparam logic [WIDTH_MAX-1:0] MASK_RESET = '1;

  // Even parity: the returned bit makes the total count of ones even.
  // Zero-extension of narrower words does not change the result.
  function automatic logic even_parity(input logic [WIDTH_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// One elastic pipeline stage: a data register plus a valid bit with a
// valid/ready handshake on each side. The stage accepts a new word whenever it
// is empty or its current word leaves in the same cycle, so a chain of these
// runs at one word per cycle with no bubbles.
module inv_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  // Room for a word when empty, or when the held word advances this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Capture the upstream word or drain the held word to the next stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset along with the valid bit so the output word reads zero out of reset.
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage see its neighbour's pre-edge value, so a word moves one stage per edge.
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= in_data;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/inv_pipe.sv
// inv_pipe: DEPTH-stage elastic pipeline that XORs each accepted word with a
// programmable invert mask on entry to stage 0 and then carries it unchanged
// to the output. Counts delivered words and reports whether any stage is busy.
// Optional feature: define INV_PIPE_PARITY_EN to add out_parity, the even
// parity of the processed word, computed at stage 0 and carried with it.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt,
`ifdef INV_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  // Stage count held inside the supported range.
  localparam int N_STAGES = (DEPTH < 1) ? 1 : ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);

  // Payload carried through the stages: the data word, plus its parity bit on top when enabled.
`ifdef INV_PIPE_PARITY_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif

  localparam logic [WIDTH-1:0] MASK_INIT = MASK_RESET[WIDTH-1:0];

  logic [WIDTH-1:0]    mask_q;
  logic [WIDTH-1:0]    masked;
  logic [PW-1:0]       head_payload;
  logic [N_STAGES-1:0] stage_valid;
  cnt_t                cnt_q;
  logic                deliver;

  // Invert mask; a word accepted on the load edge still sees the old mask
  // because stage 0 samples the register's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_INIT;
    end else if (mask_we) begin
      mask_q <= mask_data;
    end
  end

  assign masked = in_data ^ mask_q;

  // Build the stage-0 payload from the masked word (and its parity).
  always_comb begin
    // NOTE: default the whole vector first so every bit is assigned on every path and no latch is inferred.
    head_payload            = '0;
    head_payload[WIDTH-1:0] = masked;
`ifdef INV_PIPE_PARITY_EN
    head_payload[WIDTH]     = even_parity(WIDTH_MAX'(masked));
`endif
  end

  // Stage chain. Each generate block owns its own link signals so the ready
  // path from the output back to stage 0 is a plain chain of separate nets.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic          up_valid;
    logic          up_ready;
    logic [PW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [PW-1:0] dn_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = head_payload;
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
    end

    if (k == N_STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_stage[k+1].up_ready;
    end

    inv_pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (up_data),
      .out_valid (dn_valid),
      .out_ready (dn_ready),
      .out_data  (dn_data)
    );

    assign stage_valid[k] = dn_valid;
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[N_STAGES-1].dn_valid;
  assign out_data  = g_stage[N_STAGES-1].dn_data[WIDTH-1:0];
`ifdef INV_PIPE_PARITY_EN
  assign out_parity = g_stage[N_STAGES-1].dn_data[WIDTH];
`endif

  assign deliver = out_valid && out_ready;
  assign busy    = |stage_valid;

  // Delivered-word counter; wraps naturally at the top of its range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_inv_pipe.sv
// Self-checking bench for inv_pipe (WIDTH=8, DEPTH=2). A queue-based model
// tracks every accepted word (input XOR the mask in force at acceptance) and
// the delivered count; directed tables and sequences cover the corner cases.
// Define INV_PIPE_PARITY_EN for both bench and RTL to cover the parity build.
module tb_inv_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mask_we;
  logic [WIDTH-1:0] mask_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      xfer_cnt;
  logic             busy;
`ifdef INV_PIPE_PARITY_EN
  logic             out_parity;
`endif

  always #5 clk = ~clk;

  inv_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_cnt   (xfer_cnt),
`ifdef INV_PIPE_PARITY_EN
    .out_parity (out_parity),
`endif
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] din;
    logic       mw;
    logic [7:0] md;
    logic [7:0] dout;
  } vec_t;

  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_mask;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic mw,
                       input logic [7:0] md, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    mask_we   = mw;
    mask_data = md;
    out_ready = ordy;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mask = 8'hFF;
    m_cnt  = 0;
  endtask

  // Called at the falling edge: checks the held state, then books the
  // transfers that the coming rising edge will perform.
  task automatic observe();
    logic [7:0] e;
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt[15:0]));
    check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == DEPTH && !out_ready)));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q[0];
        check("out_data", 64'(out_data), 64'(e));
`ifdef INV_PIPE_PARITY_EN
        check("out_parity", 64'(out_parity), 64'(^e));
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_cnt++;
        end
      end
    end
    if (in_valid && in_ready) exp_q.push_back(in_data ^ m_mask);
    if (mask_we) m_mask = mask_data;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [7:0]  w[4];
    logic [7:0]  got[$];
    logic [7:0]  e;
    logic [7:0]  first_out;
    int          lat;
    int          sent;
    int          cyc;
    int          acc;
    int          target;
    int unsigned cnt_before;

    n_tests = 0;
    n_fail  = 0;

    // Reset defaults.
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Single-word vectors: {input, mask load, mask value, expected output}.
    vecs[0] = '{8'h5A, 1'b0, 8'h00, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 8'h0F, 8'hFF};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h0F};
    vecs[3] = '{8'hF0, 1'b0, 8'h00, 8'hFF};
    vecs[4] = '{8'h3C, 1'b1, 8'h00, 8'h33};
    vecs[5] = '{8'h3C, 1'b0, 8'h00, 8'h3C};
    vecs[6] = '{8'hA5, 1'b1, 8'hFF, 8'hA5};
    vecs[7] = '{8'h12, 1'b0, 8'h00, 8'hED};
    for (int i = 0; i < 8; i++) begin
      cnt_before = m_cnt;
      drive(1'b1, vecs[i].din, vecs[i].mw, vecs[i].md, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      lat = 1;
      while (!out_valid && lat < 16) begin
        step();
        lat++;
      end
      check("vec_latency", 64'(lat), 64'(DEPTH));
      check("vec_out", 64'(out_data), 64'(vecs[i].dout));
      step();
      check("vec_xfer_cnt", 64'(xfer_cnt), 64'(cnt_before + 1));
    end

    // Backpressure: four back-to-back words, out_ready low for the first 5 cycles.
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    sent = 0;
    cyc  = 0;
    got.delete();
    while ((sent < 4 || got.size() < 4) && cyc < 40) begin
      drive(sent < 4, w[sent & 3], 1'b0, 8'h00, cyc >= 5);
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_out_stable", 64'(out_data), 64'(8'hEE));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got.push_back(out_data);
      observe();
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_in_time", 64'(cyc < 40), 64'(1));
    check("bp_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size() && i < 4; i++) begin
      e = ~w[i];
      check("bp_order", 64'(got[i]), 64'(e));
    end

    // Random traffic with random mask loads and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
            8'($urandom), $urandom_range(0, 9) < 6);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 2) step();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_busy_idle", 64'(busy), 64'(0));

    // Reset with two words in flight.
    drive(1'b1, 8'h77, 1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b1, 8'h88, 1'b0, 8'h00, 1'b0);
    step();
    check("mid_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    check("mid_release_out_valid", 64'(out_valid), 64'(0));
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    acc       = 0;
    first_out = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (acc == 0) first_out = out_data;
        acc++;
      end
      observe();
      @(posedge clk);
      #1;
    end
    check("mid_deliveries", 64'(acc), 64'(1));
    check("mid_mask_reset", 64'(first_out), 64'(8'hFF));

`ifdef INV_PIPE_PARITY_EN
    // Parity build: 0x01 through the reset mask gives 0xFE, seven ones.
    drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    lat = 1;
    while (!out_valid && lat < 16) begin
      step();
      lat++;
    end
    check("par_out", 64'(out_data), 64'(8'hFE));
    check("par_bit", 64'(out_parity), 64'(1));
    step();
`endif

    // Counter wrap: stream until 0xFFFF deliveries, then one more.
    target = 65535 - int'(m_cnt);
    sent   = 0;
    cyc    = 0;
    while (sent < target && cyc < 70000) begin
      drive(1'b1, 8'(cyc), 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      observe();
      @(posedge clk);
      #1;
      cyc++;
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 2) step();
    check("wrap_in_time", 64'(cyc < 70000), 64'(1));
    check("wrap_pre", 64'(xfer_cnt), 64'(16'hFFFF));
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 2) step();
    check("wrap_post", 64'(xfer_cnt), 64'(16'h0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_pipe.md
INV_PIPE -- requirements
Module: inv_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port mask_we  input  1  load new invert mask.
REQ-009 SHALL have port mask_data  input  WIDTH  new invert mask; bit=1 inverts that data bit.
REQ-010 SHALL have port out_valid  output  1  output word present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port out_data  output  WIDTH  processed word.
REQ-013 SHALL have port xfer_cnt  output  16  count of words delivered at the output.
REQ-014 SHALL have port busy  output  1  high when any stage holds a valid word.

Function
REQ-015 SHALL implement a DEPTH-stage elastic pipeline, each stage a data register plus a valid bit.
REQ-016 SHALL accept a word when in_valid && in_ready and SHALL deliver a word when out_valid && out_ready.
REQ-017 SHALL capture in_data XOR mask into stage 0; all later stages copy unchanged.
REQ-018 SHALL advance stage k when it is valid and stage k+1 is empty or advancing in the same cycle (last stage: out_ready).
REQ-019 SHALL drive in_ready = !valid[0] || stage 0 advancing; full throughput of one word per cycle.
REQ-020 SHALL have latency of exactly DEPTH cycles from acceptance to out_valid when out_ready stays high.
REQ-021 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL never drop, duplicate or reorder words under any out_ready pattern.
REQ-023 SHALL load mask on the edge where mask_we=1; a word accepted in that same cycle uses the old mask.
REQ-024 SHALL increment xfer_cnt by 1 per delivered word, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL set busy = OR of all stage valid bits.

Reset
REQ-026 SHALL, while rst_n=0, clear all valid bits, all data registers and xfer_cnt to 0, and set mask to all ones (plain NOT behaviour).
REQ-027 SHALL discard in-flight words on reset assertion mid-operation; out_valid=0 and in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when INV_PIPE_PARITY_EN is defined, add output out_parity (1 bit): even parity of out_data, computed at stage 0 and carried with the word.
REQ-029 SHALL, when INV_PIPE_PARITY_EN is undefined, omit out_parity and all parity logic; all other behaviour is identical.

Structure
REQ-030 SHALL place DEPTH_MAX=8, CNT_W=16 and the reset-mask rule (all ones) in shared package inv_pipe_pkg.
REQ-031 SHALL build the pipeline from DEPTH instances of sub-module inv_pipe_stage (one data+valid register with valid/ready).

Verification
REQ-032 SHALL check reset defaults: WIDTH=8, DEPTH=2, in 0x5A streamed, out_ready=1 -> out 0xA5 two cycles later, xfer_cnt=1.
REQ-033 SHALL check mask: mask_we with mask_data=0x0F in the same cycle as accepting 0x00 -> that word out 0xFF; next word 0x00 -> 0x0F.
REQ-034 SHALL check backpressure: 4 back-to-back words, out_ready low 3 cycles -> in_ready low after 2 buffered words, out_data stable, all 4 delivered in order.
REQ-035 SHALL check wrap: preload 0xFFFF deliveries (or force) then one more -> xfer_cnt=0x0000.
REQ-036 SHALL check reset mid-stream: rst_n low with 2 words in flight -> out_valid=0, busy=0, mask=0xFF, no stale word after release.
REQ-037 SHALL check parity build: INV_PIPE_PARITY_EN, input 0x01 with reset mask -> out 0xFE, out_parity=1.
